// File: rtl/bf_pkg.sv
// Shared definitions for the bellmanford output-memory side: word and
// address geometry, the infinity encoding and the drain state encoding.
package bf_pkg;

    localparam int BF_ADDR_W = 13;
    localparam int BF_DATA_W = 16;
    localparam int BF_DEPTH  = 8192;

    localparam logic [BF_DATA_W-1:0] BF_INF_VAL = 16'hFFFF;

    // Drain controller states; the bellmanford controller shares this encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_NEG    = 3'd4
    } bf_state_t;

endpackage : bf_pkg

// File: rtl/om_drain_if.sv
// Valid/ready stream carrying one distance word per beat, tagged with its
// vertex index, an infinity flag and an end-of-sweep marker.
interface om_drain_if
    import bf_pkg::*;
#(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_inf;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_inf,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_inf,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface : om_drain_if

// File: rtl/om_drain.sv
// Output-memory drain for bellmanford. After Finish it sweeps the memory
// read port from address 0 to DEPTH-1 and streams each distance word,
// flagging and counting unreachable (infinity) entries. After NegCycle it
// streams nothing and raises neg_flag instead.
//
// The read port is combinational, so OMAR runs one word ahead of the word
// on the stream (OMAR == out_index+1, saturated at DEPTH-1). On a handshake
// the prefetched OMDR is loaded straight into the output register, which
// keeps the stream at one word per cycle with no skid buffer.
module om_drain
    import bf_pkg::*;
#(
    parameter int                ADDR_W  = BF_ADDR_W,
    parameter int                DATA_W  = BF_DATA_W,
    parameter int                DEPTH   = BF_DEPTH,
    parameter logic [DATA_W-1:0] INF_VAL = DATA_W'(BF_INF_VAL)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Finish,
    input  logic              NegCycle,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    om_drain_if.master        os,
    output logic              busy,
    output logic              done,
    output logic              neg_flag,
    output logic [ADDR_W:0]   inf_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    // Next read address, held at the final word so the sweep never wraps.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a >= LAST_IDX) ? LAST_IDX : a + 1'b1;
    endfunction

    bf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] omar_q, omar_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              inf_q, inf_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              neg_q, neg_d;
    logic [ADDR_W:0]   inf_count_q, inf_count_d;

    logic [ADDR_W-1:0] index_inc;
    logic              beat;

    assign index_inc = index_q + 1'b1;
    assign beat      = valid_q && os.out_ready;

    // Next-state and next-output computation for the drain controller.
    always_comb begin
        state_d     = state_q;
        omar_d      = omar_q;
        valid_d     = valid_q;
        data_d      = data_q;
        inf_d       = inf_q;
        index_d     = index_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = done_q;
        neg_d       = neg_q;
        inf_count_d = inf_count_q;

        case (state_q)
            ST_IDLE: begin
                omar_d = '0;
                // A negative cycle makes every distance meaningless, so it
                // wins over a simultaneous Finish.
                if (NegCycle) begin
                    state_d = ST_NEG;
                    neg_d   = 1'b1;
                    done_d  = 1'b1;
                end else if (Finish) begin
                    state_d     = ST_PRIME;
                    busy_d      = 1'b1;
                    inf_count_d = '0;
                end
            end

            ST_PRIME: begin
                data_d  = OMDR;
                index_d = '0;
                inf_d   = (OMDR == INF_VAL);
                last_d  = (LAST_IDX == '0);
                valid_d = 1'b1;
                omar_d  = next_addr('0);
                state_d = ST_STREAM;
            end

            ST_STREAM: begin
                if (beat) begin
                    inf_count_d = inf_count_q + {{ADDR_W{1'b0}}, inf_q};
                    if (last_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        data_d  = OMDR;
                        index_d = index_inc;
                        inf_d   = (OMDR == INF_VAL);
                        last_d  = (index_inc == LAST_IDX);
                        omar_d  = next_addr(omar_q);
                    end
                end
            end

            ST_DONE: begin
                // Finish is a level; wait for it to drop so one completion
                // never triggers a second sweep.
                if (!Finish) begin
                    done_d  = 1'b0;
                    omar_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_NEG: begin
                if (!NegCycle && !Finish) begin
                    neg_d   = 1'b0;
                    done_d  = 1'b0;
                    omar_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                omar_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                neg_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            omar_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            inf_q       <= 1'b0;
            index_q     <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            neg_q       <= 1'b0;
            inf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            omar_q      <= omar_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            inf_q       <= inf_d;
            index_q     <= index_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            neg_q       <= neg_d;
            inf_count_q <= inf_count_d;
        end
    end

    assign OMAR         = omar_q;
    assign os.out_valid = valid_q;
    assign os.out_data  = data_q;
    assign os.out_inf   = inf_q;
    assign os.out_index = index_q;
    assign os.out_last  = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign neg_flag     = neg_q;
    assign inf_count    = inf_count_q;

endmodule : om_drain

// File: tb/tb_om_drain.sv
// Bench for om_drain: a behavioural memory image feeds the read port and a
// queue of expected (data, index) words is consumed as beats are accepted.
module tb_om_drain;
    import bf_pkg::*;

    localparam int AW    = BF_ADDR_W;
    localparam int DW    = BF_DATA_W;
    localparam int DEPTH = BF_DEPTH;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          Finish;
    logic          NegCycle;
    logic [AW-1:0] OMAR;
    logic [DW-1:0] OMDR;
    logic          busy;
    logic          done;
    logic          neg_flag;
    logic [AW:0]   inf_count;

    om_drain_if #(.ADDR_W(AW), .DATA_W(DW)) os ();

    om_drain #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .Finish   (Finish),
        .NegCycle (NegCycle),
        .OMAR     (OMAR),
        .OMDR     (OMDR),
        .os       (os),
        .busy     (busy),
        .done     (done),
        .neg_flag (neg_flag),
        .inf_count(inf_count)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:DEPTH-1];
    assign OMDR = mem[OMAR];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
    } exp_t;
    exp_t sb[$];

    task automatic load_default_image();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'd7;
        mem[0] = 16'd5;
        mem[1] = 16'hFFFF;
    endtask

    // Full sweep with scoreboard; pct is the per-cycle out_ready probability.
    task automatic drain_and_score(input int pct, input int exp_inf, input int exp_cyc, input string tag);
        int   cyc;
        int   first_v;
        int   words;
        bit   got_done;
        exp_t e;
        logic [AW-1:0] want_a;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) sb.push_back('{data: mem[i], idx: AW'(i)});
        @(negedge clock);
        Finish   = 1'b1;
        cyc      = 0;
        first_v  = 0;
        words    = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 4 * DEPTH + 100) begin
            @(negedge clock);
            cyc++;
            os.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (cyc == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_start: got %0b want 1", tag, busy); end
                n_cmp++; if (inf_count !== '0) begin n_bad++; $display("FAIL %s inf_count_cleared: got %0d want 0", tag, inf_count); end
            end
            if (os.out_valid === 1'b1) begin
                if (first_v == 0) first_v = cyc;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL %s extra_word: got index %0d want none", tag, os.out_index);
                end else begin
                    e = sb[0];
                    want_a = (e.idx >= LAST) ? LAST : e.idx + 1'b1;
                    n_cmp++; if (OMAR !== want_a) begin n_bad++; $display("FAIL %s prefetch_addr: got %0d want %0d", tag, OMAR, want_a); end
                    n_cmp++; if (os.out_data !== e.data) begin n_bad++; $display("FAIL %s data@%0d: got %0h want %0h", tag, e.idx, os.out_data, e.data); end
                    n_cmp++; if (os.out_index !== e.idx) begin n_bad++; $display("FAIL %s index: got %0d want %0d", tag, os.out_index, e.idx); end
                    n_cmp++; if (os.out_inf !== (e.data == 16'hFFFF)) begin n_bad++; $display("FAIL %s inf@%0d: got %0b want %0b", tag, e.idx, os.out_inf, e.data == 16'hFFFF); end
                    n_cmp++; if (os.out_last !== (e.idx == LAST)) begin n_bad++; $display("FAIL %s last@%0d: got %0b want %0b", tag, e.idx, os.out_last, e.idx == LAST); end
                    if (os.out_ready) begin
                        void'(sb.pop_front());
                        words++;
                    end
                end
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        n_cmp++; if (!got_done) begin n_bad++; $display("FAIL %s done_timeout: got done=%0b after %0d cycles want 1", tag, done, cyc); end
        n_cmp++; if (words != DEPTH) begin n_bad++; $display("FAIL %s word_count: got %0d want %0d", tag, words, DEPTH); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL %s words_left: got %0d want 0", tag, sb.size()); end
        n_cmp++; if (inf_count !== (AW + 1)'(exp_inf)) begin n_bad++; $display("FAIL %s inf_count: got %0d want %0d", tag, inf_count, exp_inf); end
        n_cmp++; if (os.out_valid !== 1'b0) begin n_bad++; $display("FAIL %s valid_after_done: got %0b want 0", tag, os.out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_after_done: got %0b want 0", tag, busy); end
        n_cmp++; if (first_v != 2) begin n_bad++; $display("FAIL %s first_valid_cycle: got %0d want 2", tag, first_v); end
        if (exp_cyc > 0) begin
            n_cmp++; if (cyc != exp_cyc) begin n_bad++; $display("FAIL %s sweep_cycles: got %0d want %0d", tag, cyc, exp_cyc); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Finish = 1'b0; NegCycle = 1'b0; os.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (OMAR !== '0) begin n_bad++; $display("FAIL rst OMAR: got %0h want 0", OMAR); end
        n_cmp++; if (os.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst out_valid: got %0b want 0", os.out_valid); end
        n_cmp++; if (os.out_data !== '0) begin n_bad++; $display("FAIL rst out_data: got %0h want 0", os.out_data); end
        n_cmp++; if (os.out_inf !== 1'b0) begin n_bad++; $display("FAIL rst out_inf: got %0b want 0", os.out_inf); end
        n_cmp++; if (os.out_index !== '0) begin n_bad++; $display("FAIL rst out_index: got %0h want 0", os.out_index); end
        n_cmp++; if (os.out_last !== 1'b0) begin n_bad++; $display("FAIL rst out_last: got %0b want 0", os.out_last); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst done: got %0b want 0", done); end
        n_cmp++; if (neg_flag !== 1'b0) begin n_bad++; $display("FAIL rst neg_flag: got %0b want 0", neg_flag); end
        n_cmp++; if (inf_count !== '0) begin n_bad++; $display("FAIL rst inf_count: got %0d want 0", inf_count); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_full_sweep();
        load_default_image();
        drain_and_score(100, 1, DEPTH + 2, "full");
        Finish = 1'b0;
        @(negedge clock);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL full done_cleared: got %0b want 0", done); end
        n_cmp++; if (OMAR !== '0) begin n_bad++; $display("FAIL full idle_OMAR: got %0d want 0", OMAR); end
        n_cmp++; if (inf_count !== (AW + 1)'(1)) begin n_bad++; $display("FAIL full inf_count_retained: got %0d want 1", inf_count); end
    endtask

    task automatic test_stall_sweep();
        int n_inf;
        n_inf = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if (mem[i] == 16'hFFFF) n_inf++;
        end
        drain_and_score(50, n_inf, 0, "stall");
        Finish = 1'b0;
        os.out_ready = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_neg_cycle();
        @(negedge clock);
        NegCycle = 1'b1;
        @(negedge clock);
        n_cmp++; if (neg_flag !== 1'b1) begin n_bad++; $display("FAIL neg neg_flag: got %0b want 1", neg_flag); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL neg done: got %0b want 1", done); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n_cmp++; if (os.out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL neg quiet@%0d: got valid=%0b busy=%0b want 0/0", i, os.out_valid, busy); end
        end
        NegCycle = 1'b0;
        Finish   = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (neg_flag !== 1'b1) begin n_bad++; $display("FAIL neg hold_with_finish: got %0b want 1", neg_flag); end
        Finish = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (neg_flag !== 1'b0) begin n_bad++; $display("FAIL neg exit_flag: got %0b want 0", neg_flag); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL neg exit_done: got %0b want 0", done); end
    endtask

    task automatic test_simultaneous();
        int words;
        words = 0;
        @(negedge clock);
        NegCycle = 1'b1;
        Finish   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (os.out_valid === 1'b1) words++;
        end
        n_cmp++; if (words != 0) begin n_bad++; $display("FAIL simul words: got %0d want 0", words); end
        n_cmp++; if (neg_flag !== 1'b1) begin n_bad++; $display("FAIL simul neg_flag: got %0b want 1", neg_flag); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL simul busy: got %0b want 0", busy); end
        NegCycle = 1'b0;
        Finish   = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (neg_flag !== 1'b0) begin n_bad++; $display("FAIL simul exit: got %0b want 0", neg_flag); end
    endtask

    task automatic test_reset_mid_sweep();
        int  cyc;
        bit  hit;
        load_default_image();
        @(negedge clock);
        Finish = 1'b1;
        os.out_ready = 1'b1;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            if (os.out_valid === 1'b1 && os.out_index == AW'(300)) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid reach_idx300: got index %0d want 300", os.out_index); end
        reset = 1'b0;
        #1;
        n_cmp++; if (os.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid rst_valid: got %0b want 0", os.out_valid); end
        n_cmp++; if (os.out_index !== '0) begin n_bad++; $display("FAIL mid rst_index: got %0d want 0", os.out_index); end
        n_cmp++; if (os.out_data !== '0) begin n_bad++; $display("FAIL mid rst_data: got %0h want 0", os.out_data); end
        n_cmp++; if (OMAR !== '0) begin n_bad++; $display("FAIL mid rst_OMAR: got %0d want 0", OMAR); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid rst_busy: got %0b want 0", busy); end
        n_cmp++; if (inf_count !== '0) begin n_bad++; $display("FAIL mid rst_inf_count: got %0d want 0", inf_count); end
        Finish = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        drain_and_score(100, 1, DEPTH + 2, "restart");
        Finish = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_all_inf();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
        drain_and_score(100, DEPTH, DEPTH + 2, "allinf");
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            n_cmp++; if (done !== 1'b1 || os.out_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL allinf hold@%0d: got done=%0b valid=%0b busy=%0b want 1/0/0", i, done, os.out_valid, busy);
            end
        end
        Finish = 1'b0;
        @(negedge clock);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL allinf done_drop: got %0b want 0", done); end
        load_default_image();
        drain_and_score(100, 1, DEPTH + 2, "second");
        Finish = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_stall_sweep();
        test_neg_cycle();
        test_simultaneous();
        test_reset_mid_sweep();
        test_all_inf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_om_drain

// File: doc/om_drain.md
Name: om_drain

Overview:
- Hardware reader for the output-memory side of bellmanford.
- Waits for Finish or NegCycle. On Finish, sweeps the SRAM_1R1W output memory read port from address 0 to DEPTH-1 and streams each 16-bit distance over a valid/ready interface.
- Flags 16'hFFFF entries as unreachable (infinity) and counts them.
- On NegCycle, streams nothing and reports the negative-cycle condition.
- Replaces the bench-side dump of OutputMemory.Register; sits between the output memory read port and a host/serializer.

Parameters:
- ADDR_W, 13, output memory address width
- DATA_W, 16, distance word width
- DEPTH, 8192, number of words swept (must be ≤ 2**ADDR_W)
- INF_VAL, 16'hFFFF, encoding of unreachable distance

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Finish  in  1  bellmanford completion level
- NegCycle  in  1  bellmanford negative-cycle level
- OMAR  out  ADDR_W  output memory read address
- OMDR  in  DATA_W  output memory read data, combinational from OMAR
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  distance word
- out_inf  out  1  out_data == INF_VAL
- out_index  out  ADDR_W  vertex address of out_data
- out_last  out  1  word is index DEPTH-1
- busy  out  1  drain in progress
- done  out  1  sweep or neg report complete (level)
- neg_flag  out  1  negative cycle reported
- inf_count  out  ADDR_W+1  number of INF_VAL words streamed so far

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; OMAR=0; out_valid=0; out_data=0; out_inf=0; out_index=0; out_last=0.
  - busy=0; done=0; neg_flag=0; inf_count=0.
- States: IDLE, PRIME, STREAM, DONE, NEG.
- IDLE:
  - OMAR=0.
  - NegCycle==1 → NEG. NegCycle takes priority when it is high in the same cycle as Finish.
  - Else Finish==1 → PRIME; busy=1; inf_count=0.
- PRIME (1 cycle): capture OMDR at OMAR=0 into out_data; out_index=0; out_inf set; out_last=(DEPTH==1). Then out_valid=1, OMAR=1, → STREAM.
- STREAM:
  - OMAR always holds out_index+1: one-word prefetch, sustains 1 word/cycle.
  - out_valid && !out_ready: all out_* held stable; OMAR stable.
  - Handshake on a non-last word: load OMDR into out_data; out_index++; OMAR++; update out_inf and out_last; out_valid stays 1.
  - inf_count increments on each handshake whose out_inf==1.
  - Handshake with out_last==1: out_valid=0; busy=0; done=1 → DONE.
  - OMAR saturates at DEPTH-1; it never wraps to 0 during a sweep.
- DONE:
  - done=1 held.
  - Finish==0 → IDLE with done cleared; inf_count retained until the next PRIME.
- NEG:
  - neg_flag=1, done=1, out_valid never asserted.
  - Leaves only when NegCycle==0 and Finish==0 → IDLE; neg_flag cleared.
- Finish or NegCycle deasserting during PRIME/STREAM is ignored; the sweep completes.
- NegCycle rising during STREAM is ignored; it is reported only from IDLE.
- Output memory writes (OMWE) during the sweep are not the block's concern; bellmanford is idle after Finish.
- Latency: first out_valid 2 cycles after the Finish-sampling edge. A full sweep with out_ready tied high takes DEPTH+2 cycles.
- out_inf is a registered compare, aligned with out_data.

Decomposition:
- Shared package bf_pkg:
  - ADDR_W, DATA_W, INF_VAL constants.
  - State enum shared with the bellmanford controller.
- No sub-module required. The prefetch/hold register is inline.

Test Plan:
- mem[0]=5, mem[1]=FFFF, mem[2..8191]=7; Finish=1 at t0; out_ready=1 → 8192 words in order; idx1 has out_inf=1; out_last only on idx 8191; inf_count=1; done at cycle 8194.
- out_ready toggled as a random 50% pattern during the sweep → no word dropped or duplicated; out_data/out_index stable while stalled; scoreboard matches mem image.
- NegCycle=1 with Finish=0 → neg_flag=1, done=1, out_valid stays 0 for 100 cycles; then both low → IDLE, neg_flag=0.
- NegCycle and Finish rise the same cycle → NEG path taken, zero words streamed.
- reset pulsed low mid-sweep at idx 300 → all outputs return to reset values immediately. Re-assert Finish → sweep restarts at idx 0 with inf_count=0.
- All-FFFF memory → inf_count=8192 (14-bit, no overflow); Finish held high after done → stays in DONE, no second sweep until Finish drops and rises.
